// File: rtl/rocc_accum_responder_pkg.sv
// Shared types for the RoCC accumulator responder: command/response payloads,
// funct encodings, instruction field positions and the responder FSM states.
package rocc_accum_responder_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } rocc_resp_t;

  typedef enum logic [2:0] {
    ROCC_WRITE = 3'd0,
    ROCC_READ  = 3'd1,
    ROCC_ACCUM = 3'd2,
    ROCC_MUL   = 3'd3
  } rocc_funct_e;

  localparam int unsigned FunctMsb = 31;
  localparam int unsigned FunctLsb = 25;
  localparam int unsigned XdBit    = 14;
  localparam int unsigned RdMsb    = 11;
  localparam int unsigned RdLsb    = 7;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  // Only funct 0..3 with the upper four bits clear are supported.
  function automatic logic funct_legal(input logic [6:0] funct);
    return (funct[6:3] == 4'd0) && (funct[2:0] <= 3'd3);
  endfunction

endpackage

// File: rtl/rocc_iter_mul.sv
// Iterative unsigned 64x64 multiplier keeping the low 64 product bits,
// consuming MulBitsPerCycle multiplier bits per cycle after a start pulse.
module rocc_iter_mul #(
  parameter int unsigned MulBitsPerCycle = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] multiplicand_i,
  input  logic [63:0] multiplier_i,
  output logic        done_o,
  output logic [63:0] product_o
);

  localparam int unsigned NumSteps = 64 / MulBitsPerCycle;
  localparam int unsigned CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;

  logic            running_q;
  logic [CntW-1:0] cnt_q;
  logic [63:0]     mcand_q;
  logic [63:0]     mplier_q;
  logic [63:0]     product_q;
  logic [63:0]     digit;
  logic [63:0]     partial;

  // Multiplicand is pre-shifted each step, so the partial product needs no extra shift.
  assign digit     = 64'(mplier_q[MulBitsPerCycle-1:0]);
  assign partial   = mcand_q * digit;
  assign product_o = product_q + partial;
  assign done_o    = running_q && (cnt_q == CntW'(NumSteps - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else if (start_i) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
      mcand_q   <= multiplicand_i;
      mplier_q  <= multiplier_i;
      product_q <= '0;
    end else if (running_q) begin
      product_q <= product_o;
      mcand_q   <= mcand_q << MulBitsPerCycle;
      mplier_q  <= mplier_q >> MulBitsPerCycle;
      cnt_q     <= cnt_q + 1'b1;
      if (done_o) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rocc_accum_responder.sv
// RoCC accelerator endpoint: executes WRITE/READ/ACCUM/MUL on a bank of 64-bit
// accumulators and answers instructions that request a destination write.
module rocc_accum_responder
  import rocc_accum_responder_pkg::*;
#(
  parameter int unsigned NumAcc          = 4,
  parameter int unsigned MulBitsPerCycle = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  rocc_cmd_t  rocc_cmd_i,
  input  logic       rocc_cmd_valid_i,
  output logic       rocc_cmd_ready_o,
  output rocc_resp_t rocc_resp_o,
  output logic       rocc_resp_valid_o,
  input  logic       rocc_resp_ready_i,
  output logic       busy_o,
  output logic       illegal_o
);

  localparam int unsigned IdxW = $clog2(NumAcc);

  state_e          state_q, state_d;
  logic [63:0]     acc_q [NumAcc];
  logic [IdxW-1:0] idx_q, idx_d;
  logic [4:0]      rd_q, rd_d;
  logic            xd_q, xd_d;
  logic [63:0]     data_q, data_d;

  logic            acc_we;
  logic [IdxW-1:0] acc_widx;
  logic [63:0]     acc_wdata;
  logic [63:0]     acc_sum;

  logic [6:0]      funct;
  logic            xd;
  logic [4:0]      rd;
  logic [IdxW-1:0] idx;
  logic            accept;
  logic [63:0]     acc_sel;
  logic            mul_start;
  logic            mul_done;
  logic [63:0]     mul_product;
  logic            unused_cmd_bits;

  assign funct   = rocc_cmd_i.instr[FunctMsb:FunctLsb];
  assign xd      = rocc_cmd_i.instr[XdBit];
  assign rd      = rocc_cmd_i.instr[RdMsb:RdLsb];
  assign idx     = rocc_cmd_i.rs2[IdxW-1:0];
  assign acc_sel = acc_q[idx];
  assign acc_sum = acc_sel + rocc_cmd_i.rs1;

  assign unused_cmd_bits = ^{rocc_cmd_i.instr[24:15], rocc_cmd_i.instr[13:12],
                             rocc_cmd_i.instr[6:0], rocc_cmd_i.rs2[63:IdxW]};

  assign rocc_cmd_ready_o  = (state_q == StIdle);
  assign accept            = rocc_cmd_valid_i && rocc_cmd_ready_o && !rst_i;
  assign busy_o            = (state_q != StIdle);
  assign rocc_resp_valid_o = (state_q == StResp);
  assign rocc_resp_o       = '{rd: rd_q, data: data_q};
  assign illegal_o         = accept && !funct_legal(funct);

  rocc_iter_mul #(
    .MulBitsPerCycle (MulBitsPerCycle)
  ) u_mul (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (mul_start),
    .multiplicand_i (acc_sel),
    .multiplier_i   (rocc_cmd_i.rs1),
    .done_o         (mul_done),
    .product_o      (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    xd_d      = xd_q;
    data_d    = data_q;
    acc_we    = 1'b0;
    acc_widx  = idx;
    acc_wdata = rocc_cmd_i.rs1;
    mul_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = idx;
          rd_d    = rd;
          xd_d    = xd;
          state_d = xd ? StResp : StIdle;
          if (!funct_legal(funct)) begin
            data_d = '1;
          end else begin
            case (rocc_funct_e'(funct[2:0]))
              ROCC_WRITE: begin
                acc_we = 1'b1;
                data_d = '0;
              end
              ROCC_READ:  data_d = acc_sel;
              ROCC_ACCUM: begin
                acc_we    = 1'b1;
                acc_wdata = acc_sum;
                data_d    = acc_sum;
              end
              ROCC_MUL: begin
                mul_start = 1'b1;
                state_d   = StExec;
              end
              default: data_d = '1;
            endcase
          end
        end
      end
      StExec: begin
        if (mul_done) begin
          acc_we    = 1'b1;
          acc_widx  = idx_q;
          acc_wdata = mul_product;
          data_d    = mul_product;
          state_d   = xd_q ? StResp : StIdle;
        end
      end
      StResp: begin
        if (rocc_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rd_q    <= '0;
      xd_q    <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < NumAcc; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      xd_q    <= xd_d;
      data_q  <= data_d;
      if (acc_we) acc_q[acc_widx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_rocc_accum_responder.sv
// Directed self-checking bench for rocc_accum_responder with hand-computed
// expected values; inputs change and outputs are sampled 1ns after each rising edge.
module tb_rocc_accum_responder;
  import rocc_accum_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  rocc_cmd_t  cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  rocc_resp_t resp;
  logic       resp_valid;
  logic       resp_ready;
  logic       busy;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rocc_accum_responder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .rocc_cmd_i        (cmd),
    .rocc_cmd_valid_i  (cmd_valid),
    .rocc_cmd_ready_o  (cmd_ready),
    .rocc_resp_o       (resp),
    .rocc_resp_valid_o (resp_valid),
    .rocc_resp_ready_i (resp_ready),
    .busy_o            (busy),
    .illegal_o         (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] funct, input logic xd,
                                           input logic [4:0] rd);
    return {funct, 5'd0, 5'd0, xd, 2'b00, rd, 7'b0001011};
  endfunction

  task automatic drive(input logic [6:0] funct, input logic xd, input logic [4:0] rd,
                       input logic [63:0] rs1, input logic [63:0] rs2);
    cmd.instr = mk_instr(funct, xd, rd);
    cmd.rs1   = rs1;
    cmd.rs2   = rs2;
    cmd_valid = 1'b1;
  endtask

  // Drives one command through its acceptance edge; returns in cycle 1.
  task automatic issue(input string tag, input logic [6:0] funct, input logic xd,
                       input logic [4:0] rd, input logic [63:0] rs1, input logic [63:0] rs2);
    drive(funct, xd, rd, rs1, rs2);
    #1;
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [63:0] exp);
    issue(tag, 7'd1, 1'b1, 5'd1, 64'd0, 64'(idx));
    chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
    chk({tag, "_data"}, resp.data, exp);
    step();
  endtask

  initial begin
    rst        = 1'b1;
    cmd        = '0;
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp", 64'(resp.data) | 64'(resp.rd), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);

    // READ idx 2, rd 5, valid in cycle 1
    issue("rd2", 7'd1, 1'b1, 5'd5, 64'd0, 64'd2);
    chk("rd2_valid", 64'(resp_valid), 64'd1);
    chk("rd2_rd", 64'(resp.rd), 64'd5);
    chk("rd2_data", resp.data, 64'd0);
    chk("rd2_ready_low", 64'(cmd_ready), 64'd0);
    step();
    chk("rd2_done", 64'(resp_valid), 64'd0);

    // WRITE then ACCUM wrap-around, back-to-back (xd=0 stays idle)
    issue("wr1", 7'd0, 1'b0, 5'd0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("wr1_busy", 64'(busy), 64'd0);
    issue("acc1", 7'd2, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFF5, 64'd1);
    chk("acc1_valid", 64'(resp_valid), 64'd1);
    chk("acc1_rd", 64'(resp.rd), 64'd3);
    chk("acc1_data", resp.data, 64'h5);
    step();
    read_chk("rd1", 1, 64'h5);

    // MUL with a held command during EXEC that must not be accepted
    issue("wr0", 7'd0, 1'b0, 5'd0, 64'h1_0000_0003, 64'd0);
    issue("mul", 7'd3, 1'b1, 5'd7, 64'h2_0000_0005, 64'd0);
    drive(7'd0, 1'b0, 5'd0, 64'hDEAD, 64'd2);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("mul_busy_c%0d", c), 64'(busy), 64'd1);
      chk($sformatf("mul_ready_c%0d", c), 64'(cmd_ready), 64'd0);
      chk($sformatf("mul_valid_c%0d", c), 64'(resp_valid), 64'd0);
      step();
    end
    cmd_valid = 1'b0;
    chk("mul_busy_c9", 64'(busy), 64'd1);
    chk("mul_valid_c9", 64'(resp_valid), 64'd1);
    chk("mul_rd", 64'(resp.rd), 64'd7);
    chk("mul_data", resp.data, 64'h0000_000B_0000_000F);
    step();
    chk("mul_busy_c10", 64'(busy), 64'd0);
    read_chk("rd0_mul", 0, 64'h0000_000B_0000_000F);
    read_chk("rd2_untouched", 2, 64'd0);

    // Response backpressure
    resp_ready = 1'b0;
    issue("bp", 7'd1, 1'b1, 5'd9, 64'd0, 64'd1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 64'(resp_valid), 64'd1);
      chk($sformatf("bp_data_c%0d", c), resp.data, 64'h5);
      chk($sformatf("bp_rd_c%0d", c), 64'(resp.rd), 64'd9);
      chk($sformatf("bp_ready_c%0d", c), 64'(cmd_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    chk("bp_valid_c6", 64'(resp_valid), 64'd1);
    step();
    chk("bp_ready_after", 64'(cmd_ready), 64'd1);
    chk("bp_valid_after", 64'(resp_valid), 64'd0);

    // Illegal funct 0x15
    drive(7'h15, 1'b1, 5'd2, 64'd123, 64'd1);
    #1;
    chk("ill_pulse", 64'(illegal), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ill_pulse_end", 64'(illegal), 64'd0);
    chk("ill_valid", 64'(resp_valid), 64'd1);
    chk("ill_data", resp.data, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    // funct 4 is also unsupported; xd=0 gives no response
    drive(7'h04, 1'b0, 5'd0, 64'd77, 64'd3);
    #1;
    chk("ill4_pulse", 64'(illegal), 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("ill4_busy", 64'(busy), 64'd0);
    read_chk("ill_acc0", 0, 64'h0000_000B_0000_000F);
    read_chk("ill_acc1", 1, 64'h5);
    read_chk("ill_acc2", 2, 64'd0);
    read_chk("ill_acc3", 3, 64'd0);

    // Reset in cycle 4 of a MUL
    issue("mulrst", 7'd3, 1'b1, 5'd4, 64'd3, 64'd1);
    step();
    step();
    step();
    chk("mulrst_busy_c4", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mulrst_busy", 64'(busy), 64'd0);
    chk("mulrst_valid", 64'(resp_valid), 64'd0);
    chk("mulrst_ready", 64'(cmd_ready), 64'd1);
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("mulrst_novalid_c%0d", c), 64'(resp_valid), 64'd0);
    end
    read_chk("mulrst_acc0", 0, 64'd0);
    read_chk("mulrst_acc1", 1, 64'd0);
    read_chk("mulrst_acc2", 2, 64'd0);
    read_chk("mulrst_acc3", 3, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
